// File: rtl/icap_pkg.sv
// Shared definitions for the ICAP stream writer: FSM state encodings,
// error-class codes and the per-byte bit-reversal helper.
package icap_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned ERR_W   = 2;

    // FSM state encodings
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_ARMED = 3'd1;
    localparam logic [STATE_W-1:0] ST_WRITE = 3'd2;
    localparam logic [STATE_W-1:0] ST_FLUSH = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;
    localparam logic [STATE_W-1:0] ST_ERR   = 3'd5;

    // Error classes reported on ERR_CODE
    localparam logic [ERR_W-1:0] ERR_NONE    = 2'b00;
    localparam logic [ERR_W-1:0] ERR_PRERROR = 2'b01;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [ERR_W-1:0] ERR_ABORT   = 2'b11;

    // Reverse bit order inside each byte; byte positions are unchanged
    function automatic logic [31:0] bitswap32(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                r[8*k+j] = d[8*k+7-j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_timeout_cnt.sv
// FLUSH-phase timeout counter.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_clr forces the
// count to zero; i_en advances it; o_expire_c is high while the count equals
// LIMIT-1 (the count saturates there).
module icap_timeout_cnt #(
    parameter int unsigned LIMIT = 4096
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire_c
);

    localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [CW-1:0] r_cnt;

    assign o_expire_c = (r_cnt == CW'(LIMIT - 1));

    // Count up from zero, hold at the expiry value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire_c) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/icap_stream_writer.sv
// ICAP initiator: takes a 32-bit bitstream stream and writes it into the
// ICAPE3 wrapper, honouring AVAIL and watching PRDONE/PRERROR.
// Ports: CLK/RESETN clock and async active-low reset; START/ABORT control;
// S_TDATA/S_TVALID/S_TLAST/S_TREADY input stream; CSIB/RDWRB/I/AVAIL/
// PRDONE/PRERROR ICAP side; BUSY/DONE/ERROR/ERR_CODE/WORD_CNT status.
module icap_stream_writer
    import icap_pkg::*;
#(
    parameter bit          BIT_SWAP       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic             ABORT,
    input  logic [31:0]      S_TDATA,
    input  logic             S_TVALID,
    input  logic             S_TLAST,
    output logic             S_TREADY,
    output logic             CSIB,
    output logic             RDWRB,
    output logic [31:0]      I,
    input  logic             AVAIL,
    input  logic             PRDONE,
    input  logic             PRERROR,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERROR,
    output logic [1:0]       ERR_CODE,
    output logic [CNT_W-1:0] WORD_CNT
);

    logic [STATE_W-1:0] r_state;
    logic               r_csib;
    logic [31:0]        r_i;
    logic [CNT_W-1:0]   r_word_cnt;
    logic               r_done;
    logic               r_error;
    logic [ERR_W-1:0]   r_err_code;

    logic [STATE_W-1:0] w_state_nxt;
    logic               w_csib_nxt;
    logic [31:0]        w_i_nxt;
    logic [CNT_W-1:0]   w_word_cnt_nxt;
    logic               w_done_nxt;
    logic               w_error_nxt;
    logic [ERR_W-1:0]   w_err_code_nxt;
    logic               w_hs;
    logic               w_expire;
    logic               w_in_flush;
    logic [31:0]        w_data_sw;

    assign w_in_flush = (r_state == ST_FLUSH);
    assign w_data_sw  = BIT_SWAP ? bitswap32(S_TDATA) : S_TDATA;

    // Ready follows AVAIL directly so a falling AVAIL stalls the same cycle
    assign S_TREADY = (r_state == ST_WRITE) && AVAIL;
    assign w_hs     = S_TREADY && S_TVALID;

    assign RDWRB    = 1'b0;
    assign CSIB     = r_csib;
    assign I        = r_i;
    assign BUSY     = (r_state == ST_ARMED) || (r_state == ST_WRITE) || w_in_flush;
    assign DONE     = r_done;
    assign ERROR    = r_error;
    assign ERR_CODE = r_err_code;
    assign WORD_CNT = r_word_cnt;

    icap_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk      (CLK),
        .i_rst_n    (RESETN),
        .i_clr      (!w_in_flush),
        .i_en       (w_in_flush),
        .o_expire_c (w_expire)
    );

    // State register and registered outputs
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state    <= ST_IDLE;
            r_csib     <= 1'b1;
            r_i        <= '0;
            r_word_cnt <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_csib     <= w_csib_nxt;
            r_i        <= w_i_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    // Next state and next registered outputs; CSIB deasserts unless a word
    // is handed over this cycle, which also drops any word on an error exit
    always_comb begin
        w_state_nxt    = r_state;
        w_csib_nxt     = 1'b1;
        w_i_nxt        = r_i;
        w_word_cnt_nxt = r_word_cnt;
        w_done_nxt     = r_done;
        w_error_nxt    = r_error;
        w_err_code_nxt = r_err_code;

        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (START) begin
                    w_state_nxt    = ST_ARMED;
                    w_done_nxt     = 1'b0;
                    w_error_nxt    = 1'b0;
                    w_err_code_nxt = ERR_NONE;
                    w_word_cnt_nxt = '0;
                end
            end
            ST_ARMED, ST_WRITE, ST_FLUSH: begin
                if (PRERROR) begin
                    w_state_nxt    = ST_ERR;
                    w_error_nxt    = 1'b1;
                    w_err_code_nxt = ERR_PRERROR;
                end else if (ABORT) begin
                    w_state_nxt    = ST_ERR;
                    w_error_nxt    = 1'b1;
                    w_err_code_nxt = ERR_ABORT;
                end else if (r_state == ST_ARMED) begin
                    if (AVAIL) begin
                        w_state_nxt = ST_WRITE;
                    end
                end else if (r_state == ST_WRITE) begin
                    if (w_hs) begin
                        w_csib_nxt     = 1'b0;
                        w_i_nxt        = w_data_sw;
                        w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
                        if (S_TLAST) begin
                            w_state_nxt = ST_FLUSH;
                        end
                    end
                end else begin
                    if (PRDONE) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else if (w_expire) begin
                        w_state_nxt    = ST_ERR;
                        w_error_nxt    = 1'b1;
                        w_err_code_nxt = ERR_TIMEOUT;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icap_stream_writer.sv
// Directed self-checking bench for icap_stream_writer. A second instance
// with BIT_SWAP=0 shares all inputs and runs in lockstep with the first.
module tb_icap_stream_writer;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        START, ABORT;
    logic [31:0] S_TDATA;
    logic        S_TVALID, S_TLAST;
    logic        AVAIL, PRDONE, PRERROR;

    logic        S_TREADY, CSIB, RDWRB, BUSY, DONE, ERROR;
    logic [31:0] I;
    logic [1:0]  ERR_CODE;
    logic [31:0] WORD_CNT;

    logic        n_tready, n_csib, n_rdwrb, n_busy, n_done, n_error;
    logic [31:0] n_i;
    logic [1:0]  n_err_code;
    logic [31:0] n_word_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    icap_stream_writer #(
        .BIT_SWAP(1'b1), .TIMEOUT_CYCLES(16), .CNT_W(32)
    ) u_dut (
        .CLK(CLK), .RESETN(RESETN), .START(START), .ABORT(ABORT),
        .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TLAST(S_TLAST),
        .S_TREADY(S_TREADY), .CSIB(CSIB), .RDWRB(RDWRB), .I(I),
        .AVAIL(AVAIL), .PRDONE(PRDONE), .PRERROR(PRERROR),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERR_CODE(ERR_CODE),
        .WORD_CNT(WORD_CNT)
    );

    icap_stream_writer #(
        .BIT_SWAP(1'b0), .TIMEOUT_CYCLES(16), .CNT_W(32)
    ) u_dut_ns (
        .CLK(CLK), .RESETN(RESETN), .START(START), .ABORT(ABORT),
        .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TLAST(S_TLAST),
        .S_TREADY(n_tready), .CSIB(n_csib), .RDWRB(n_rdwrb), .I(n_i),
        .AVAIL(AVAIL), .PRDONE(PRDONE), .PRERROR(PRERROR),
        .BUSY(n_busy), .DONE(n_done), .ERROR(n_error), .ERR_CODE(n_err_code),
        .WORD_CNT(n_word_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic idle_inputs();
        START = 0; ABORT = 0; S_TDATA = '0; S_TVALID = 0; S_TLAST = 0;
        PRDONE = 0; PRERROR = 0;
    endtask

    // START pulse, then one cycle in ARMED with AVAIL=1 to reach WRITE
    task automatic arm();
        AVAIL = 1; START = 1;
        tick();
        START = 0;
        check("armed_busy", 32'(BUSY), 32'd1);
        tick();
    endtask

    // Offer one word with AVAIL=1 and check it appears on I the next cycle
    task automatic push(input logic [31:0] w, input logic last,
                        input logic [31:0] exp_i, input logic [31:0] exp_cnt);
        S_TDATA = w; S_TVALID = 1; S_TLAST = last;
        tick();
        check("word_csib", 32'(CSIB), 32'd0);
        check("word_i", I, exp_i);
        check("word_cnt", WORD_CNT, exp_cnt);
        S_TVALID = 0; S_TLAST = 0;
    endtask

    task automatic finish_with_prdone(input int wait_cycles);
        tick();
        check("flush_csib_idle", 32'(CSIB), 32'd1);
        ticks(wait_cycles);
        PRDONE = 1;
        tick();
        PRDONE = 0;
        check("done_flag", 32'(DONE), 32'd1);
        check("done_busy", 32'(BUSY), 32'd0);
        check("done_error", 32'(ERROR), 32'd0);
    endtask

    initial begin
        idle_inputs();
        AVAIL = 0;
        RESETN = 0;
        ticks(3);

        // Reset values
        check("rst_csib", 32'(CSIB), 32'd1);
        check("rst_rdwrb", 32'(RDWRB), 32'd0);
        check("rst_i", I, 32'd0);
        check("rst_tready", 32'(S_TREADY), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_error", 32'(ERROR), 32'd0);
        check("rst_errcode", 32'(ERR_CODE), 32'd0);
        check("rst_wordcnt", WORD_CNT, 32'd0);
        RESETN = 1;
        tick();

        // Basic 4-word transfer with bit swap, PRDONE 10 cycles after last word
        arm();
        push(32'h000000BB, 1'b0, 32'h000000DD, 32'd1);
        push(32'h11220044, 1'b0, 32'h88440022, 32'd2);
        push(32'hAA995566, 1'b0, 32'h5599AA66, 32'd3);
        push(32'h20000000, 1'b1, 32'h04000000, 32'd4);
        check("rdwrb_low", 32'(RDWRB), 32'd0);
        finish_with_prdone(8);
        check("t1_wordcnt", WORD_CNT, 32'd4);
        check("t1_tready_done", 32'(S_TREADY), 32'd0);

        // Same stream with a 3-cycle AVAIL gap after the 2nd word
        arm();
        push(32'h000000BB, 1'b0, 32'h000000DD, 32'd1);
        push(32'h11220044, 1'b0, 32'h88440022, 32'd2);
        S_TDATA = 32'hAA995566; S_TVALID = 1; AVAIL = 0;
        for (int g = 0; g < 3; g++) begin
            #1;
            check("gap_tready", 32'(S_TREADY), 32'd0);
            tick();
            check("gap_csib", 32'(CSIB), 32'd1);
            check("gap_cnt", WORD_CNT, 32'd2);
        end
        AVAIL = 1;
        push(32'hAA995566, 1'b0, 32'h5599AA66, 32'd3);
        push(32'h20000000, 1'b1, 32'h04000000, 32'd4);
        finish_with_prdone(3);
        check("t2_wordcnt", WORD_CNT, 32'd4);

        // BIT_SWAP=0 instance passes data through unchanged
        arm();
        push(32'h12345678, 1'b1, 32'h482C6A1E, 32'd1);
        check("noswap_i", n_i, 32'h12345678);
        check("noswap_csib", 32'(n_csib), 32'd0);
        finish_with_prdone(2);
        check("noswap_done", 32'(n_done), 32'd1);

        // Timeout: no PRDONE, ERR_S reached 16 cycles into FLUSH
        arm();
        push(32'h00000001, 1'b1, 32'h00000080, 32'd1);
        ticks(15);
        check("to_still_busy", 32'(BUSY), 32'd1);
        check("to_no_error_yet", 32'(ERROR), 32'd0);
        tick();
        check("to_error", 32'(ERROR), 32'd1);
        check("to_errcode", 32'(ERR_CODE), 32'd2);
        check("to_busy", 32'(BUSY), 32'd0);
        check("to_done", 32'(DONE), 32'd0);

        // PRERROR during the 3rd word, together with PRDONE
        arm();
        push(32'h000000BB, 1'b0, 32'h000000DD, 32'd1);
        push(32'h11220044, 1'b0, 32'h88440022, 32'd2);
        S_TDATA = 32'hAA995566; S_TVALID = 1; PRERROR = 1; PRDONE = 1;
        tick();
        PRERROR = 0; PRDONE = 0;
        check("pe_csib", 32'(CSIB), 32'd1);
        check("pe_errcode", 32'(ERR_CODE), 32'd1);
        check("pe_error", 32'(ERROR), 32'd1);
        check("pe_done", 32'(DONE), 32'd0);
        #1;
        check("pe_tready", 32'(S_TREADY), 32'd0);
        S_TVALID = 0;
        // START rearms and clears status
        START = 1;
        tick();
        START = 0;
        check("rearm_error", 32'(ERROR), 32'd0);
        check("rearm_errcode", 32'(ERR_CODE), 32'd0);
        check("rearm_wordcnt", WORD_CNT, 32'd0);
        check("rearm_busy", 32'(BUSY), 32'd1);
        tick();

        // START while busy is ignored; ABORT mid-stream
        push(32'h000000F0, 1'b0, 32'h0000000F, 32'd1);
        START = 1;
        push(32'h000000C0, 1'b0, 32'h00000003, 32'd2);
        START = 0;
        ABORT = 1;
        tick();
        ABORT = 0;
        check("ab_errcode", 32'(ERR_CODE), 32'd3);
        check("ab_error", 32'(ERROR), 32'd1);
        check("ab_csib", 32'(CSIB), 32'd1);
        check("ab_busy", 32'(BUSY), 32'd0);

        // RESETN low mid-stream: asynchronous return to reset values
        arm();
        S_TDATA = 32'h00000003; S_TVALID = 1;
        tick();
        check("pre_rst_csib", 32'(CSIB), 32'd0);
        check("pre_rst_busy", 32'(BUSY), 32'd1);
        #2;
        RESETN = 0;
        #1;
        check("arst_csib", 32'(CSIB), 32'd1);
        check("arst_busy", 32'(BUSY), 32'd0);
        check("arst_wordcnt", WORD_CNT, 32'd0);
        check("arst_i", I, 32'd0);
        check("arst_tready", 32'(S_TREADY), 32'd0);
        S_TVALID = 0;
        tick();
        RESETN = 1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
